div_seq: RTL and testbench
==========================

# div_seq

Parametrised sequential shift-subtract divider: WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock, with busy/done/ack handshake, divide-by-zero detection and optional signed mode. Serves as the shared long-latency divide unit beside the ALU. A requester pulses `start`, waits for `done`, reads results and acknowledges with `ack`.

## Interface
- `WIDTH`, default 32: operand and result width, legal range 4..64.
- `CNT_W`, default $clog2(WIDTH+1): bit-count register width. Derived; do not override.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `ack`  in  1  result consumed; sampled only in DONE.
- `is_signed`  in  1  two's-complement operation when 1. Sampled with `start`.
- `dividend`  in  WIDTH  sampled with `start`.
- `divisor`  in  WIDTH  sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  high only in DONE.
- `div_by_zero`  out  1  result came from a zero divisor. Valid while `done` is high.
- `quotient`  out  WIDTH  result; held stable while `done` is high.
- `remainder`  out  WIDTH  result; sign follows the dividend in signed mode.

## Operation
- States: IDLE, CALC, FIXUP (present only with the macro), DONE. One-hot encoding.
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero`, `quotient`, `remainder` and the counter all go to 0. No X values.
- IDLE, with `start`=1:
  - Latch the operands. In signed mode, latch their magnitudes and record both sign bits.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - If the divisor is 0, go straight to DONE:
    - `quotient` = all ones.
    - `remainder` = dividend, raw, not negated.
    - `div_by_zero` = 1.
  - Otherwise go to CALC.
- CALC, each cycle:
  - Form t = {pr[WIDTH-1:0], q[WIDTH-1]}.
  - Shift q left by one.
  - If t >= d: pr = t - d and q[0] = 1. Else: pr = t and q[0] = 0.
  - Increment the counter.
  - After WIDTH iterations, go to FIXUP if compiled in, else DONE.
  - Comparison is unsigned, WIDTH+1 bits, so it cannot overflow.
- FIXUP:
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend was negative.
  - Go to DONE.
- DONE:
  - Hold all outputs.
  - When `ack`=1, go to IDLE. `done` drops on the next cycle; results keep their values until the next `start`.
- `start` outside IDLE is ignored, including when `start` and `ack` arrive together in DONE. A new request needs `start` in IDLE.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0, with no special-case logic. This falls out of magnitude arithmetic.

## Timing
- Cycle 0 is the edge that samples `start` in IDLE.
- Unsigned build: `done` is first high after edge WIDTH+1.
- Signed build: `done` is first high after edge WIDTH+2, constant for both `is_signed` values.
- Divide by zero: `done` high after edge 1.
- `busy` rises after edge 0 and falls after the edge that samples `ack`.
- Minimum request-to-request period: latency + 2 cycles (the DONE cycle with `ack`, then one IDLE cycle).
- Reset mid-operation: IDLE and reset values on the next edge. No partial result is exposed.
- `rst` overrides `start` and `ack` in the same cycle.

## Configuration
- `DIV_SEQ_SIGNED_EN` defined:
  - Sign capture, magnitude conversion and the FIXUP state are compiled in.
  - `is_signed` is honoured.
  - Latency is WIDTH+2.
- Macro undefined:
  - No FIXUP state or negation logic.
  - `is_signed` is ignored; every operation is unsigned.
  - Latency is WIDTH+1.
  - The port list is identical in both builds.

## Test plan
- WIDTH=32, unsigned, 100 / 7 → `quotient`=14, `remainder`=2, `div_by_zero`=0. `done` rises exactly WIDTH+1 cycles after `start` (WIDTH+2 in the signed build).
- 5 / 0 → `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1, `done` after one cycle.
- Signed build, `is_signed`=1:
  - -7 / 2 → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0.
- Hold `ack` low 5 cycles in DONE while pulsing `start` with new operands → outputs unchanged and `done` stays high. Then `ack` and `start` together → IDLE, no new operation begins.
- Assert `rst` 10 cycles after `start` → next cycle `busy`=0, `done`=0, all outputs 0. Then 0xFFFFFFFF / 0x10 → `quotient`=0x0FFFFFFF, `remainder`=0xF.
- WIDTH=8 instance, 200 / 3 unsigned → `quotient`=66, `remainder`=2, `done` after 9 cycles (unsigned build).

Source files
------------

// File: rtl/div_seq.sv
// Sequential shift-subtract divider: one quotient bit per clock, busy/done/ack handshake, divide-by-zero flag.
// Optional signed mode (magnitude arithmetic plus a FIXUP state) is compiled in with `define DIV_SEQ_SIGNED_EN.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CALC  = 4'b0010,
`ifdef DIV_SEQ_SIGNED_EN
        S_FIXUP = 4'b0100,
`endif
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] pr_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   t_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic             last_s;
    logic             zero_div_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;

`ifdef DIV_SEQ_SIGNED_EN
    logic             neg_q_r;
    logic             neg_r_r;
    logic             sa_s;
    logic             sb_s;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and sign bits captured at start
    always_comb begin
        sa_s    = is_signed & dividend[WIDTH-1];
        sb_s    = is_signed & divisor[WIDTH-1];
        a_mag_s = dividend;
        b_mag_s = divisor;
        if (sa_s) begin
            a_mag_s = twos_neg(dividend);
        end else begin
            a_mag_s = dividend;
        end
        if (sb_s) begin
            b_mag_s = twos_neg(divisor);
        end else begin
            b_mag_s = divisor;
        end
    end
`else
    logic unused_is_signed_s;

    // Unsigned-only build: operands pass straight through, is_signed has no effect
    always_comb begin
        unused_is_signed_s = is_signed;
        a_mag_s            = dividend;
        b_mag_s            = divisor;
    end
`endif

    // One shift-subtract step; t is WIDTH+1 bits so the compare cannot overflow
    always_comb begin
        t_s        = {pr_r, q_r[WIDTH-1]};
        ge_s       = (t_s >= {1'b0, d_r});
        diff_s     = t_s[WIDTH-1:0] - d_r;
        last_s     = (cnt_r == CNT_LAST);
        zero_div_s = (divisor == ZERO_W);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (zero_r) begin
                    state_s = S_DONE;
                end else if (last_s) begin
`ifdef DIV_SEQ_SIGNED_EN
                    state_s = S_FIXUP;
`else
                    state_s = S_DONE;
`endif
                end else begin
                    state_s = S_CALC;
                end
            end
`ifdef DIV_SEQ_SIGNED_EN
            S_FIXUP: begin
                state_s = S_DONE;
            end
`endif
            S_DONE: begin
                if (ack) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_s == S_DONE);
        end
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pr_r        <= ZERO_W;
            q_r         <= ZERO_W;
            d_r         <= ZERO_W;
            cnt_r       <= {CNT_W{1'b0}};
            zero_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
`ifdef DIV_SEQ_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        // A zero divisor keeps the raw dividend for the remainder output
                        q_r    <= zero_div_s ? dividend : a_mag_s;
                        d_r    <= b_mag_s;
                        pr_r   <= ZERO_W;
                        cnt_r  <= {CNT_W{1'b0}};
                        zero_r <= zero_div_s;
`ifdef DIV_SEQ_SIGNED_EN
                        neg_q_r <= sa_s ^ sb_s;
                        neg_r_r <= sa_s;
`endif
                    end
                end
                S_CALC: begin
                    if (zero_r) begin
                        quotient_r  <= ONES_W;
                        remainder_r <= q_r;
                        dbz_r       <= 1'b1;
                    end else if (last_s) begin
                        dbz_r <= 1'b0;
`ifndef DIV_SEQ_SIGNED_EN
                        quotient_r  <= q_r;
                        remainder_r <= pr_r;
`endif
                    end else begin
                        q_r   <= {q_r[WIDTH-2:0], ge_s};
                        pr_r  <= ge_s ? diff_s : t_s[WIDTH-1:0];
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef DIV_SEQ_SIGNED_EN
                S_FIXUP: begin
                    quotient_r  <= neg_q_r ? twos_neg(q_r) : q_r;
                    remainder_r <= neg_r_r ? twos_neg(pr_r) : pr_r;
                end
`endif
                default: begin
                    zero_r <= zero_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, handshake corners, mid-op reset and random operands
// against an arithmetic reference model; a second WIDTH=8 instance covers the narrow configuration.
module tb_div_seq;

`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam int LAT32 = SIGNED_BUILD ? 34 : 33;
    localparam int LAT8  = SIGNED_BUILD ? 10 : 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        start8 = 1'b0;
    logic        ack8 = 1'b0;
    logic [7:0]  dividend8 = 8'd0;
    logic [7:0]  divisor8 = 8'd0;
    logic        busy8, done8, dbz8;
    logic [7:0]  quotient8, remainder8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ack(ack8), .is_signed(1'b0),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .quotient(quotient8), .remainder(remainder8)
    );

    // Reference: plain integer division; SV '/' truncates toward zero and '%' follows the dividend
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (sgn && SIGNED_BUILD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [31:0] q, output logic [31:0] r, output logic dz, output int lat);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic ack_result(input string name);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r, eq, er;
        logic dz, edz;
        int lat, elat;
        model(a, b, sgn, eq, er, edz);
        elat = (b == 32'd0) ? 1 : LAT32;
        run_op(a, b, sgn, q, r, dz, lat);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, elat);
        end
        checks++;
        if (q !== eq || r !== er || dz !== edz) begin
            errors++;
            $display("FAIL %s_result (%h/%h s=%b): q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                     name, a, b, sgn, q, r, dz, eq, er, edz);
        end
        ack_result(name);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b dz=%b q=%h r=%h, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || quotient8 !== 8'd0 || remainder8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_values8: busy=%b done=%b q=%h r=%h, required all 0",
                     busy8, done8, quotient8, remainder8);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op("u100_7", 32'd100, 32'd7, 1'b0);
        check_op("div0", 32'd5, 32'd0, 1'b0);
        check_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_op("s_div0", 32'hFFFF_FFF9, 32'd0, 1'b1);
        check_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_op("u_small_big", 32'd3, 32'hF000_0000, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            check_op("random", a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_hold_in_done();
        logic [31:0] q, r, eq, er;
        logic dz, edz;
        int lat;
        model(32'd1000, 32'd9, 1'b0, eq, er, edz);
        run_op(32'd1000, 32'd9, 1'b0, q, r, dz, lat);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; dividend = $urandom; divisor = 32'd3;
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                errors++;
                $display("FAIL hold_done[%0d]: done=%b q=%h r=%h, required 1 q=%h r=%h", i, done, quotient, remainder, eq, er);
            end
        end
        ack = 1'b1; start = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== eq) begin
            errors++;
            $display("FAIL ack_with_start: busy=%b done=%b q=%h, required 0 0 q=%h", busy, done, quotient, eq);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_new_op: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        // Ack then one IDLE cycle before the next start: the minimum request period
        check_op("b2b_a", 32'd77, 32'd5, 1'b0);
        check_op("b2b_b", 32'd123456, 32'd1000, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        dividend = 32'h1234_5678; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b dz=%b q=%h r=%h, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        check_op("after_reset", 32'hFFFF_FFFF, 32'h10, 1'b0);
    endtask

    task automatic test_width8();
        logic [7:0] a, b;
        int lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 8'd200; b = 8'd3;
            end else begin
                a = 8'($urandom); b = 8'($urandom_range(1, 255));
            end
            @(negedge clk);
            dividend8 = a; divisor8 = b; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0; lat = 0;
            while (done8 !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== LAT8 || quotient8 !== a / b || remainder8 !== a % b || dbz8 !== 1'b0) begin
                errors++;
                $display("FAIL w8 %0d/%0d: lat=%0d q=%0d r=%0d dz=%b, required lat=%0d q=%0d r=%0d dz=0",
                         a, b, lat, quotient8, remainder8, dbz8, LAT8, a / b, a % b);
            end
            ack8 = 1'b1;
            @(negedge clk);
            ack8 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_in_done();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
